// File: rtl/game_round_ctrl.sv
// Game-round controller: turns the seconds counter's BCD elapsed time into a
// round state machine, a BCD time-remaining display and a gated 3-digit BCD score.
module game_round_ctrl #(
  parameter int GAME_SECONDS = 60
) (
  input  logic        ClockIn,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Hit,
  input  logic [3:0]  TensIn,
  input  logic [3:0]  OnesIn,
  output logic        CounterReset,
  output logic        GameActive,
  output logic        GameOver,
  output logic [3:0]  TimeLeftTens,
  output logic [3:0]  TimeLeftOnes,
  output logic [11:0] Score
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PLAYING = 2'd2,
    OVER    = 2'd3
  } state_e;

  localparam logic [6:0] GameSecs = 7'(GAME_SECONDS);
  localparam logic [3:0] GsTens   = 4'(GAME_SECONDS / 10);
  localparam logic [3:0] GsOnes   = 4'(GAME_SECONDS % 10);

  state_e      state_q, state_d;
  logic        start_q, hit_q;
  logic        counter_reset_q, counter_reset_d;
  logic        game_active_q, game_active_d;
  logic        game_over_q, game_over_d;
  logic [3:0]  tl_tens_q, tl_tens_d;
  logic [3:0]  tl_ones_q, tl_ones_d;
  logic [11:0] score_q, score_d;

  logic       start_edge, hit_edge, time_up;
  logic [3:0] tens_c, ones_c;
  logic [6:0] elapsed, remaining;

  // BCD increment with per-digit carry; caller handles saturation at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] val);
    logic [11:0] res;
    logic        carry;
    res   = val;
    carry = 1'b1;
    for (int d = 0; d < 3; d++) begin
      if (carry) begin
        if (val[d*4 +: 4] == 4'd9) begin
          res[d*4 +: 4] = 4'd0;
        end else begin
          res[d*4 +: 4] = val[d*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    start_edge = Start & ~start_q;
    hit_edge   = Hit & ~hit_q;

    tens_c    = (TensIn > 4'd9) ? 4'd9 : TensIn;
    ones_c    = (OnesIn > 4'd9) ? 4'd9 : OnesIn;
    elapsed   = {3'b000, tens_c} * 7'd10 + {3'b000, ones_c};
    time_up   = (elapsed >= GameSecs);
    remaining = time_up ? 7'd0 : (GameSecs - elapsed);

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_edge) state_d = ARM;
      ARM:     state_d = PLAYING;
      PLAYING: if (time_up) state_d = OVER;
      OVER:    if (start_edge) state_d = ARM;
      default: state_d = IDLE;
    endcase

    // A hit only counts if the round is still running after this edge.
    score_d = score_q;
    if (state_d == ARM) begin
      score_d = 12'h000;
    end else if (state_q == PLAYING && state_d == PLAYING && hit_edge &&
                 score_q != 12'h999) begin
      score_d = bcd_inc(score_q);
    end

    // Outputs are derived from the next state so they line up with it.
    counter_reset_d = (state_d != PLAYING);
    game_active_d   = (state_d == PLAYING);
    game_over_d     = (state_d == OVER) && (state_q != OVER);
    tl_tens_d       = GsTens;
    tl_ones_d       = GsOnes;
    unique case (state_d)
      PLAYING: begin
        tl_tens_d = 4'(remaining / 7'd10);
        tl_ones_d = 4'(remaining % 7'd10);
      end
      OVER: begin
        tl_tens_d = 4'd0;
        tl_ones_d = 4'd0;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q         <= IDLE;
      start_q         <= 1'b0;
      hit_q           <= 1'b0;
      counter_reset_q <= 1'b1;
      game_active_q   <= 1'b0;
      game_over_q     <= 1'b0;
      tl_tens_q       <= GsTens;
      tl_ones_q       <= GsOnes;
      score_q         <= 12'h000;
    end else begin
      state_q         <= state_d;
      start_q         <= Start;
      hit_q           <= Hit;
      counter_reset_q <= counter_reset_d;
      game_active_q   <= game_active_d;
      game_over_q     <= game_over_d;
      tl_tens_q       <= tl_tens_d;
      tl_ones_q       <= tl_ones_d;
      score_q         <= score_d;
    end
  end

  assign CounterReset = counter_reset_q;
  assign GameActive   = game_active_q;
  assign GameOver     = game_over_q;
  assign TimeLeftTens = tl_tens_q;
  assign TimeLeftOnes = tl_ones_q;
  assign Score        = score_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: one instance with a 5 s round, one with 60 s.
module tb_game_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start5, hit5, start60, hit60;
  logic [3:0]  tens5, ones5, tens60, ones60;
  logic        cr5, ga5, go5, cr60, ga60, go60;
  logic [3:0]  tt5, to5, tt60, to60;
  logic [11:0] sc5, sc60;

  int n_checks = 0;
  int n_errors = 0;

  game_round_ctrl #(.GAME_SECONDS(5)) u_dut5 (
    .ClockIn(clk), .Reset(rst), .Start(start5), .Hit(hit5),
    .TensIn(tens5), .OnesIn(ones5),
    .CounterReset(cr5), .GameActive(ga5), .GameOver(go5),
    .TimeLeftTens(tt5), .TimeLeftOnes(to5), .Score(sc5)
  );

  game_round_ctrl #(.GAME_SECONDS(60)) u_dut60 (
    .ClockIn(clk), .Reset(rst), .Start(start60), .Hit(hit60),
    .TensIn(tens60), .OnesIn(ones60),
    .CounterReset(cr60), .GameActive(ga60), .GameOver(go60),
    .TimeLeftTens(tt60), .TimeLeftOnes(to60), .Score(sc60)
  );

  // {CounterReset, GameActive, GameOver, TimeLeft(2 BCD digits), Score}
  logic [22:0] obs5, obs60;
  assign obs5  = {cr5, ga5, go5, tt5, to5, sc5};
  assign obs60 = {cr60, ga60, go60, tt60, to60, sc60};

  function automatic logic [22:0] expv(input logic cr, input logic ga, input logic go,
                                       input logic [7:0] tl, input logic [11:0] sc);
    return {cr, ga, go, tl, sc};
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] e;
    rst = 1'b1;
    repeat (2) tick();
    e = expv(1'b1, 1'b0, 1'b0, 8'h05, 12'h000);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL reset5: got %h expected %h", obs5, e); end
    e = expv(1'b1, 1'b0, 1'b0, 8'h60, 12'h000);
    n_checks++;
    if (obs60 !== e) begin n_errors++; $display("FAIL reset60: got %h expected %h", obs60, e); end
    rst = 1'b0;
    tick();
    e = expv(1'b1, 1'b0, 1'b0, 8'h05, 12'h000);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL idle_hold: got %h expected %h", obs5, e); end
  endtask

  task automatic test_full_round();
    logic [22:0] e;
    start5 = 1'b1;
    tick();
    e = expv(1'b1, 1'b0, 1'b0, 8'h05, 12'h000);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL round_arm: got %h expected %h", obs5, e); end
    tick();
    e = expv(1'b0, 1'b1, 1'b0, 8'h05, 12'h000);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL round_play: got %h expected %h", obs5, e); end
    start5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      ones5 = 4'(k);
      tick();
      if (k < 5) e = expv(1'b0, 1'b1, 1'b0, {4'd0, 4'(5 - k)}, 12'h000);
      else       e = expv(1'b1, 1'b0, 1'b1, 8'h00, 12'h000);
      n_checks++;
      if (obs5 !== e) begin n_errors++; $display("FAIL round_step %0d: got %h expected %h", k, obs5, e); end
      repeat (9) tick();
    end
    e = expv(1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL over_hold: got %h expected %h", obs5, e); end
    ones5 = 4'd0;
  endtask

  task automatic test_score();
    logic [22:0] e;
    start5 = 1'b1;
    tick();
    tick();
    start5 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      hit5 = 1'b1;
      tick();
      n_checks++;
      if (sc5 !== to_bcd(i)) begin n_errors++; $display("FAIL score_pulse %0d: got %h expected %h", i, sc5, to_bcd(i)); end
      hit5 = 1'b0;
      tick();
      tick();
    end
    hit5 = 1'b1;
    repeat (20) tick();
    hit5 = 1'b0;
    tick();
    n_checks++;
    if (sc5 !== 12'h013) begin n_errors++; $display("FAIL score_held_hit: got %h expected 013", sc5); end
    ones5 = 4'd5;
    tick();
    e = expv(1'b1, 1'b0, 1'b1, 8'h00, 12'h013);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL score_over: got %h expected %h", obs5, e); end
    ones5 = 4'd0;
    hit5 = 1'b1;
    tick();
    hit5 = 1'b0;
    tick();
    e = expv(1'b1, 1'b0, 1'b0, 8'h00, 12'h013);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL hit_in_over: got %h expected %h", obs5, e); end
  endtask

  task automatic test_back_to_back_start_hit();
    logic [22:0] e;
    start5 = 1'b1;
    hit5   = 1'b1;
    tick();
    e = expv(1'b1, 1'b0, 1'b0, 8'h05, 12'h000);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL start_hit_over: got %h expected %h", obs5, e); end
    start5 = 1'b0;
    hit5   = 1'b0;
    tick();
    e = expv(1'b0, 1'b1, 1'b0, 8'h05, 12'h000);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL restart_play: got %h expected %h", obs5, e); end
  endtask

  task automatic test_boundary();
    logic [22:0] e;
    hit5 = 1'b1;
    tick();
    hit5 = 1'b0;
    tick();
    ones5 = 4'd5;
    hit5  = 1'b1;
    tick();
    e = expv(1'b1, 1'b0, 1'b1, 8'h00, 12'h001);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL hit_at_end: got %h expected %h", obs5, e); end
    hit5 = 1'b0;
    tick();
    e = expv(1'b1, 1'b0, 1'b0, 8'h00, 12'h001);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL gameover_once: got %h expected %h", obs5, e); end
    ones5 = 4'd0;
  endtask

  task automatic test_saturation();
    logic [22:0] e;
    logic [11:0] es;
    start5 = 1'b1;
    tick();
    tick();
    start5 = 1'b0;
    for (int i = 1; i <= 1005; i++) begin
      hit5 = 1'b1;
      tick();
      hit5 = 1'b0;
      tick();
      if (i == 500 || i == 999 || i == 1000 || i == 1005) begin
        es = (i >= 999) ? 12'h999 : to_bcd(i);
        n_checks++;
        if (sc5 !== es) begin n_errors++; $display("FAIL sat_hits %0d: got %h expected %h", i, sc5, es); end
      end
    end
    ones5 = 4'd5;
    tick();
    ones5 = 4'd0;
    e = expv(1'b1, 1'b0, 1'b1, 8'h00, 12'h999);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL sat_over: got %h expected %h", obs5, e); end
  endtask

  task automatic test_mid_reset();
    logic [22:0] e;
    start5 = 1'b1;
    tick();
    tick();
    start5 = 1'b0;
    hit5 = 1'b1;
    tick();
    hit5 = 1'b0;
    ones5 = 4'd3;
    tick();
    e = expv(1'b0, 1'b1, 1'b0, 8'h02, 12'h001);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL mid_play: got %h expected %h", obs5, e); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = expv(1'b1, 1'b0, 1'b0, 8'h05, 12'h000);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL mid_reset: got %h expected %h", obs5, e); end
    ones5 = 4'd0;
    start5 = 1'b1;
    tick();
    tick();
    start5 = 1'b0;
    e = expv(1'b0, 1'b1, 1'b0, 8'h05, 12'h000);
    n_checks++;
    if (obs5 !== e) begin n_errors++; $display("FAIL mid_restart: got %h expected %h", obs5, e); end
  endtask

  task automatic test_game60();
    logic [22:0] e;
    logic [3:0]  tv [5];
    logic [3:0]  ov [5];
    logic [7:0]  tl [5];
    logic        fin [5];
    tv = '{4'h1, 4'h5, 4'h9, 4'hC, 4'h6};
    ov = '{4'hC, 4'h9, 4'h9, 4'h0, 4'h0};
    tl = '{8'h41, 8'h01, 8'h00, 8'h00, 8'h00};
    fin = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if (i < 3 ? (i == 0) : 1'b1) begin
        tens60 = 4'd0;
        ones60 = 4'd0;
        start60 = 1'b1;
        tick();
        tick();
        start60 = 1'b0;
        e = expv(1'b0, 1'b1, 1'b0, 8'h60, 12'h000);
        n_checks++;
        if (obs60 !== e) begin n_errors++; $display("FAIL g60_start %0d: got %h expected %h", i, obs60, e); end
      end
      tens60 = tv[i];
      ones60 = ov[i];
      tick();
      e = expv(fin[i], ~fin[i], fin[i], tl[i], 12'h000);
      n_checks++;
      if (obs60 !== e) begin n_errors++; $display("FAIL g60_elapsed %0d: got %h expected %h", i, obs60, e); end
      if (fin[i]) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    start5 = 1'b0; hit5 = 1'b0; tens5 = 4'd0; ones5 = 4'd0;
    start60 = 1'b0; hit60 = 1'b0; tens60 = 4'd0; ones60 = 4'd0;
    test_reset();
    test_full_round();
    test_score();
    test_back_to_back_start_hit();
    test_boundary();
    test_saturation();
    test_mid_reset();
    test_game60();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
